// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and the word-organised data memory.
// One request in flight; checks alignment and window range, drives a word-wide
// command with byte enables and lane-shifted data, and shapes returned load data.

// Store-path byte lane: picks its enable bit and data byte for one memory lane.
module mau_st_lane #(
  parameter int LANE = 0
) (
  input  logic        is_h,
  input  logic        is_b,
  input  logic        is_l,
  input  logic        is_r,
  input  logic [1:0]  off,
  input  logic [31:0] rt,
  output logic        be,
  output logic [7:0]  data
);
  localparam logic [1:0] LN = 2'(LANE);

  logic [31:0] shr, shl;

  // Left stores move the high bytes of rt down; right stores move the low bytes up.
  assign shr = rt >> {2'd3 - off, 3'b000};
  assign shl = rt << {off, 3'b000};

  // Per-lane enable and data selection; full word is the fallback.
  always_comb begin
    be   = 1'b1;
    data = rt[8*LANE +: 8];
    if (is_h) begin
      be   = (off[1] == LN[1]);
      data = rt[8*(LANE%2) +: 8];
    end else if (is_b) begin
      be   = (off == LN);
      data = rt[7:0];
    end else if (is_l) begin
      be   = (LN <= off);
      data = shr[8*LANE +: 8];
    end else if (is_r) begin
      be   = (LN >= off);
      data = shl[8*LANE +: 8];
    end
  end
endmodule

module mem_access_unit #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter int unsigned DM_BYTES = 12288
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;
  localparam logic [2:0] OP_L  = 3'd5;
  localparam logic [2:0] OP_R  = 3'd6;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_ADEL = 2'd1;
  localparam logic [1:0] EXC_ADES = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
  } req_t;

  state_t state, state_n;
  req_t   r;
  logic [31:0] res_q;
  logic [1:0]  exc_q;

  // Request decode (combinational on the raw inputs, used only at acceptance)
  logic [2:0]  op_n;
  logic [1:0]  off_in;
  logic [32:0] rel;
  logic        misal, oor, illegal;

  // Reserved op 7 behaves as a full word access.
  assign op_n    = (req_op == 3'd7) ? OP_W : req_op;
  assign off_in  = req_addr[1:0];
  assign misal   = ((op_n == OP_W) && (off_in != 2'd0)) ||
                   (((op_n == OP_H) || (op_n == OP_HU)) && off_in[0]);
  // 33-bit offset from the window base: a borrow means below the window, no wrap.
  assign rel     = {1'b0, req_addr} - {1'b0, DM_BASE};
  assign oor     = rel[32] || (rel >= 33'(DM_BYTES));
  assign illegal = misal || oor;

  // Store lanes from the registered request
  logic [1:0]                     off;
  logic [NUM_LANES-1:0]           st_be;
  logic [NUM_LANES-1:0][7:0]      st_data;
  logic                           is_h, is_b, is_l, is_r;

  assign off  = r.addr[1:0];
  assign is_h = (r.op == OP_H) || (r.op == OP_HU);
  assign is_b = (r.op == OP_B) || (r.op == OP_BU);
  assign is_l = (r.op == OP_L);
  assign is_r = (r.op == OP_R);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mau_st_lane #(.LANE(g)) u_lane (
      .is_h (is_h),
      .is_b (is_b),
      .is_l (is_l),
      .is_r (is_r),
      .off  (off),
      .rt   (r.rt),
      .be   (st_be[g]),
      .data (st_data[g])
    );
  end

  // Load result shaping: extraction, extension and left/right merge with rt.
  logic [31:0] ld_res, ld_shr;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign ld_shr  = mem_rdata >> {off, 3'b000};
  assign ld_byte = ld_shr[7:0];
  assign ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Select the load result according to the registered op and offset.
  always_comb begin
    ld_res = mem_rdata;
    case (r.op)
      OP_H:  ld_res = {{16{ld_half[15]}}, ld_half};
      OP_HU: ld_res = {16'h0000, ld_half};
      OP_B:  ld_res = {{24{ld_byte[7]}}, ld_byte};
      OP_BU: ld_res = {24'h000000, ld_byte};
      OP_L: begin
        case (off)
          2'd0:    ld_res = {mem_rdata[7:0],  r.rt[23:0]};
          2'd1:    ld_res = {mem_rdata[15:0], r.rt[15:0]};
          2'd2:    ld_res = {mem_rdata[23:0], r.rt[7:0]};
          default: ld_res = mem_rdata;
        endcase
      end
      OP_R: begin
        case (off)
          2'd0:    ld_res = mem_rdata;
          2'd1:    ld_res = {r.rt[31:24], mem_rdata[31:8]};
          2'd2:    ld_res = {r.rt[31:16], mem_rdata[31:16]};
          default: ld_res = {r.rt[31:8],  mem_rdata[31:24]};
        endcase
      end
      default: ld_res = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Request capture, exception code and load result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r     <= '0;
      res_q <= '0;
      exc_q <= EXC_NONE;
    end else begin
      if (state == IDLE && req_valid) begin
        r     <= '{we: req_we, op: op_n, addr: req_addr, rt: req_wdata};
        res_q <= '0;
        exc_q <= illegal ? (req_we ? EXC_ADES : EXC_ADEL) : EXC_NONE;
      end
      if (state == WAIT && mem_rvalid) res_q <= ld_res;
    end
  end

  // Next state and all outputs; everything idles at zero outside its own state.
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_exc   = EXC_NONE;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = illegal ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = r.we;
        mem_addr  = {r.addr[31:2], 2'b00};
        mem_be    = r.we ? st_be : 4'hF;
        mem_wdata = r.we ? st_data : 32'h0;
        if (mem_ready) state_n = r.we ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = res_q;
        resp_exc   = exc_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit with a byte-addressed memory model.
module tb_mem_access_unit;
  localparam int DM_BYTES = 12288;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic        mem_valid, mem_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_access_unit #(.DM_BASE(32'h0), .DM_BYTES(DM_BYTES)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem_b [DM_BYTES];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] last_rdata, last_wdata;
  logic [1:0]  last_exc;
  logic [3:0]  last_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  task automatic set_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) mem_b[a+i] = v[8*i +: 8];
  endtask

  // Junk on request inputs while busy; must be ignored by the unit.
  task automatic garble();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy"},   32'(req_ready),  32'd1);
    chk({tag, "_rv"},    32'(resp_valid), 32'd0);
    chk({tag, "_rd"},    resp_rdata,      32'd0);
    chk({tag, "_exc"},   32'(resp_exc),   32'd0);
    chk({tag, "_mv"},    32'(mem_valid),  32'd0);
    chk({tag, "_mwe"},   32'(mem_we),     32'd0);
    chk({tag, "_mbe"},   32'(mem_be),     32'd0);
    chk({tag, "_maddr"}, mem_addr,        32'd0);
    chk({tag, "_mwd"},   mem_wdata,       32'd0);
  endtask

  // One full transaction. Called and returns at a sample point 1ns after a rising edge.
  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input int rdly, input int vdly);
    logic [2:0]  o;
    logic [1:0]  off, eexc;
    logic        bad;
    logic [3:0]  ebe;
    logic [31:0] ewd, w, erd;
    logic [15:0] h;
    logic [7:0]  b;
    int          base;
    o    = (op == 3'd7) ? 3'd0 : op;
    off  = addr[1:0];
    bad  = ((o == 3'd0) && (off != 2'd0)) || (((o == 3'd1) || (o == 3'd2)) && off[0]) ||
           ({1'b0, addr} >= 33'(DM_BYTES));
    eexc = bad ? (we ? 2'd2 : 2'd1) : 2'd0;
    base = bad ? 0 : int'(addr & 32'hFFFF_FFFC);
    ebe  = 4'hF;
    ewd  = rt;
    if (we) begin
      case (o)
        3'd1, 3'd2: begin ebe = 4'b0011 << off; ewd = {2{rt[15:0]}}; end
        3'd3, 3'd4: begin ebe = 4'b0001 << off; ewd = {4{rt[7:0]}}; end
        3'd5: begin ebe = 4'(32'hF >> (3 - int'(off))); ewd = rt >> (8 * (3 - int'(off))); end
        3'd6: begin ebe = 4'b1111 << off; ewd = rt << (8 * int'(off)); end
        default: ;
      endcase
    end
    w   = mword(base);
    erd = w;
    h   = 16'(w >> (16 * int'(off[1])));
    b   = 8'(w >> (8 * int'(off)));
    case (o)
      3'd1: erd = {{16{h[15]}}, h};
      3'd2: erd = {16'h0, h};
      3'd3: erd = {{24{b[7]}}, b};
      3'd4: erd = {24'h0, b};
      3'd5: erd = (w << (8 * (3 - int'(off)))) | (rt & ((32'h1 << (8 * (3 - int'(off)))) - 32'h1));
      3'd6: erd = (w >> (8 * int'(off))) | (rt & ~(32'hFFFF_FFFF >> (8 * int'(off))));
      default: ;
    endcase
    if (we || bad) erd = 32'h0;

    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = rt;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    chk("acc_rdy", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    last_be = 4'h0; last_wdata = 32'h0;
    if (bad) begin
      req_valid = 1'b0;
      chk("exc_mv", 32'(mem_valid), 32'd0);
    end else begin
      for (int k = 0; k <= rdly; k++) begin
        chk("is_mv",   32'(mem_valid), 32'd1);
        chk("is_rdy",  32'(req_ready), 32'd0);
        chk("is_mwe",  32'(mem_we),    32'(we));
        chk("is_addr", mem_addr,       addr & 32'hFFFF_FFFC);
        chk("is_be",   32'(mem_be),    32'(ebe));
        if (we) chk("is_wd", mem_wdata, ewd);
        last_be = mem_be; last_wdata = mem_wdata;
        garble();
        mem_ready  = (k == rdly);
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(posedge clock); #1;
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (we) begin
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) if (ebe[i]) mem_b[base+i] = ewd[8*i +: 8];
      end else begin
        for (int k = 0; k < vdly; k++) begin
          chk("wt_rv",  32'(resp_valid), 32'd0);
          chk("wt_rdy", 32'(req_ready),  32'd0);
          garble();
          mem_rvalid = 1'b0;
          @(posedge clock); #1;
        end
        garble();
        mem_rvalid = 1'b1; mem_rdata = w;
        @(posedge clock); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        req_valid = 1'b0;
      end
    end
    chk("rsp_v",   32'(resp_valid), 32'd1);
    chk("rsp_exc", 32'(resp_exc),   32'(eexc));
    chk("rsp_rd",  resp_rdata,      erd);
    last_rdata = resp_rdata; last_exc = resp_exc;
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    @(posedge clock); #1;
    chk("post_rv",  32'(resp_valid), 32'd0);
    chk("post_rdy", 32'(req_ready),  32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic       we;
    logic [2:0] op;
    logic [31:0] addr;
    for (int i = 0; i < DM_BYTES; i++) mem_b[i] = 8'($urandom);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_idle_outputs("rst");
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed cases
    do_req(1'b1, 3'd0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    chk("d1_be", 32'(last_be), 32'hF);
    chk("d1_wd", last_wdata, 32'hDEAD_BEEF);
    set_word(32'h10, 32'h80FF_1234);
    do_req(1'b0, 3'd3, 32'h13, 32'h0, 0, 0);
    chk("d2_b", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 0, 1);
    chk("d2_bu", last_rdata, 32'h0000_0080);
    do_req(1'b0, 3'd2, 32'h12, 32'h0, 1, 0);
    chk("d2_hu", last_rdata, 32'h0000_80FF);
    set_word(32'h20, 32'hAABB_CCDD);
    do_req(1'b0, 3'd6, 32'h21, 32'h1122_3344, 0, 0);
    chk("d3_lwr", last_rdata, 32'h11AA_BBCC);
    do_req(1'b1, 3'd5, 32'h22, 32'h1122_3344, 0, 0);
    chk("d3_swl_be", 32'(last_be), 32'h7);
    chk("d3_swl_wd", last_wdata, 32'h0011_2233);
    do_req(1'b0, 3'd1, 32'h11, 32'h0, 0, 0);
    chk("d4_adel", 32'(last_exc), 32'd1);
    do_req(1'b1, 3'd0, 32'(DM_BYTES), 32'h1234_5678, 0, 0);
    chk("d4_ades", 32'(last_exc), 32'd2);
    do_req(1'b0, 3'd0, 32'(DM_BYTES - 4), 32'h0, 0, 0);
    chk("d4_top_ok", 32'(last_exc), 32'd0);
    do_req(1'b0, 3'd0, 32'h40, 32'h0, 3, 2);

    // Reset while waiting for read data; the late rvalid must be dropped.
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h40; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_idle_outputs("rmid");
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rmid_norsp", 32'(resp_valid), 32'd0);
      @(posedge clock); #1;
    end
    set_word(32'h40, 32'h0102_0304);
    do_req(1'b0, 3'd0, 32'h40, 32'h0, 0, 0);
    chk("rmid_next", last_rdata, 32'h0102_0304);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      if (we) begin
        case ($urandom_range(0, 5))
          0: op = 3'd0; 1: op = 3'd1; 2: op = 3'd3;
          3: op = 3'd5; 4: op = 3'd6; default: op = 3'd7;
        endcase
      end else op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: addr = 32'(DM_BYTES) + 32'($urandom_range(0, 7));
        1: addr = $urandom_range(32'hFFFF_FFFF, 32'(DM_BYTES));
        2, 3, 4: addr = 32'($urandom_range(0, DM_BYTES - 1)) & 32'hFFFF_FFFC;
        default: addr = 32'($urandom_range(0, DM_BYTES - 1));
      endcase
      do_req(we, op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
